// File: rtl/imem_boot_loader_if.sv
// Signal bundle between the boot loader, the byte stream source, the fetch stage and the instruction RAM.
interface imem_boot_loader_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic [31:0]      fetch_addr;
    logic [31:0]      fetch_instr;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wr_data;
    logic             imem_wr_en;
    logic [31:0]      imem_rd_data;
    logic             cpu_stall;
    logic             load_done;
    logic             load_err;
    logic [CNT_W-1:0] words_loaded;

    modport slave (
        input  start, byte_valid, byte_data, fetch_addr, imem_rd_data,
        output byte_ready, fetch_instr, imem_addr, imem_wr_data, imem_wr_en,
               cpu_stall, load_done, load_err, words_loaded
    );

    modport master (
        output start, byte_valid, byte_data, fetch_addr, imem_rd_data,
        input  byte_ready, fetch_instr, imem_addr, imem_wr_data, imem_wr_en,
               cpu_stall, load_done, load_err, words_loaded
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot-time loader for the single-port instruction RAM: assembles a length-prefixed little-endian
// byte stream into words, writes them, then hands the RAM address port to instruction fetch.
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 2048,
    parameter int          CNT_W       = 16
) (
    input logic              clk,
    input logic              reset,
    imem_boot_loader_if.slave bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_HDR, S_DATA, S_WRITE, S_DONE} state_t;

    state_t           state;
    logic [1:0]       byte_cnt;
    logic [31:0]      word_q;
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] words_loaded;
    logic [CNT_W-1:0] next_count;
    logic             load_done;
    logic             load_err;
    logic             take;
    logic [31:0]      full_word;

    assign take       = bus.byte_valid && bus.byte_ready;
    assign full_word  = {bus.byte_data, word_q[23:0]};
    assign next_count = words_loaded + CNT_W'(1);

    // Byte assembly register is pure datapath and needs no reset.
    always_ff @(posedge clk) begin
        if (take) begin
            word_q[8*byte_cnt +: 8] <= bus.byte_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_HDR;
            byte_cnt     <= 2'd0;
            n_words      <= '0;
            words_loaded <= '0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            case (state)
                S_HDR: begin
                    if (take) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Oversized images are rejected before any RAM write happens.
                            if (full_word == 32'd0) begin
                                state     <= S_DONE;
                                load_done <= 1'b1;
                            end else if (full_word > 32'(DEPTH_WORDS)) begin
                                state    <= S_DONE;
                                load_err <= 1'b1;
                            end else begin
                                n_words <= full_word[CNT_W-1:0];
                                state   <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded <= next_count;
                    if (next_count == n_words) begin
                        state     <= S_DONE;
                        load_done <= 1'b1;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DONE: begin
                    if (bus.start) begin
                        state        <= S_HDR;
                        byte_cnt     <= 2'd0;
                        n_words      <= '0;
                        words_loaded <= '0;
                        load_done    <= 1'b0;
                        load_err     <= 1'b0;
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

    assign bus.byte_ready   = (state == S_HDR) || (state == S_DATA);
    assign bus.imem_wr_en   = (state == S_WRITE);
    assign bus.imem_wr_data = word_q;
    assign bus.cpu_stall    = (state != S_DONE);
    assign bus.load_done    = load_done;
    assign bus.load_err     = load_err;
    assign bus.words_loaded = words_loaded;

    // Fetch owns the address port only once loading has finished; the path is a bare mux.
    assign bus.imem_addr   = (state == S_DONE)  ? bus.fetch_addr :
                             (state == S_WRITE) ? BASE_ADDR + (32'(words_loaded) << 2) :
                                                  BASE_ADDR;
    assign bus.fetch_instr = (state == S_DONE) ? bus.imem_rd_data : NOP;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed plus randomized checks of imem_boot_loader against a byte-image reference model and a RAM model.
module tb_imem_boot_loader;
    localparam int          CNT_W = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.CNT_W(CNT_W)) bus ();

    imem_boot_loader #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(2048),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] ram [2048];
    int          wr_pulses = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] exp_w[$];
    int          tests = 0;
    int          fails = 0;

    assign bus.imem_rd_data = ram[bus.imem_addr[12:2]];

    always @(posedge clk) begin
        if (bus.imem_wr_en === 1'b1) begin
            ram[bus.imem_addr[12:2]] <= bus.imem_wr_data;
            wr_pulses <= wr_pulses + 1;
            wr_addr_q.push_back(bus.imem_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        while ($urandom_range(99) < gap) begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom);
            step();
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int t = 0; t < 16; t++) begin
            if (bus.byte_ready === 1'b1) begin
                step();
                bus.byte_valid = 1'b0;
                return;
            end
            step();
        end
        bus.byte_valid = 1'b0;
        chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic rearm();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("rearm_stall", 32'(bus.cpu_stall), 32'd1);
        chk("rearm_done", 32'(bus.load_done), 32'd0);
        chk("rearm_err", 32'(bus.load_err), 32'd0);
        chk("rearm_words", 32'(bus.words_loaded), 32'd0);
    endtask

    // Loads n random words; the model expects word i at BASE+4i, exactly n write pulses, then done.
    task automatic run_image(input int n, input int gap, input bit poke);
        logic [31:0] w;
        int          p0;
        int          idx;
        exp_w.delete();
        wr_addr_q.delete();
        p0 = wr_pulses;
        send_word(32'(n), gap);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_w.push_back(w);
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], gap);
                if (i == 0 && k == 1) begin
                    chk("load_nop", bus.fetch_instr, NOP);
                    chk("load_stall", 32'(bus.cpu_stall), 32'd1);
                    if (poke) begin
                        bus.start = 1'b1;
                        step();
                        bus.start = 1'b0;
                    end
                end
            end
        end
        for (int t = 0; t < 8 && bus.cpu_stall !== 1'b0; t++) step();
        chk("img_stall", 32'(bus.cpu_stall), 32'd0);
        chk("img_done", 32'(bus.load_done), 32'd1);
        chk("img_words", 32'(bus.words_loaded), 32'(n));
        chk("img_pulses", 32'(wr_pulses - p0), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk("img_ram", ram[i], exp_w[i]);
            if (i < wr_addr_q.size()) chk("img_addr", wr_addr_q[i], BASE + 32'(i) * 4);
        end
        idx = $urandom_range(n - 1, 0);
        bus.fetch_addr = BASE + 32'(idx) * 4;
        #1;
        chk("fetch_addr", bus.imem_addr, BASE + 32'(idx) * 4);
        chk("fetch_instr", bus.fetch_instr, exp_w[idx]);
    endtask

    initial begin
        int p0;
        logic [31:0] w0;
        logic [31:0] w1;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.fetch_addr = 32'h0;
        step();
        step();
        chk("rst_stall", 32'(bus.cpu_stall), 32'd1);
        chk("rst_done", 32'(bus.load_done), 32'd0);
        chk("rst_err", 32'(bus.load_err), 32'd0);
        chk("rst_words", 32'(bus.words_loaded), 32'd0);
        chk("rst_ready", 32'(bus.byte_ready), 32'd1);
        chk("rst_wr_en", 32'(bus.imem_wr_en), 32'd0);
        chk("rst_addr", bus.imem_addr, BASE);
        chk("rst_nop", bus.fetch_instr, NOP);
        reset = 1'b0;

        // Directed two-word image.
        p0 = wr_pulses;
        send_word(32'd2, 0);
        send_word(32'h0010_0513, 0);
        chk("w0_wr_en", 32'(bus.imem_wr_en), 32'd1);
        chk("w0_addr", bus.imem_addr, BASE);
        chk("w0_data", bus.imem_wr_data, 32'h0010_0513);
        chk("w0_nop", bus.fetch_instr, NOP);
        send_word(32'h0020_0593, 0);
        chk("w1_wr_en", 32'(bus.imem_wr_en), 32'd1);
        chk("w1_addr", bus.imem_addr, BASE + 32'd4);
        chk("w1_data", bus.imem_wr_data, 32'h0020_0593);
        chk("w1_done_early", 32'(bus.load_done), 32'd0);
        step();
        chk("dir_done", 32'(bus.load_done), 32'd1);
        chk("dir_stall", 32'(bus.cpu_stall), 32'd0);
        chk("dir_words", 32'(bus.words_loaded), 32'd2);
        chk("dir_pulses", 32'(wr_pulses - p0), 32'd2);
        chk("dir_ram0", ram[0], 32'h0010_0513);
        chk("dir_ram1", ram[1], 32'h0020_0593);
        bus.fetch_addr = 32'h4;
        #1;
        chk("dir_fetch_addr", bus.imem_addr, 32'h4);
        chk("dir_fetch_instr", bus.fetch_instr, 32'h0020_0593);

        // Empty image.
        rearm();
        p0 = wr_pulses;
        send_word(32'd0, 0);
        chk("zero_stall", 32'(bus.cpu_stall), 32'd0);
        chk("zero_done", 32'(bus.load_done), 32'd1);
        chk("zero_words", 32'(bus.words_loaded), 32'd0);
        step();
        chk("zero_pulses", 32'(wr_pulses - p0), 32'd0);

        // Oversized header.
        rearm();
        p0 = wr_pulses;
        send_word(32'd2049, 0);
        step();
        chk("err_flag", 32'(bus.load_err), 32'd1);
        chk("err_done", 32'(bus.load_done), 32'd0);
        chk("err_stall", 32'(bus.cpu_stall), 32'd0);
        chk("err_pulses", 32'(wr_pulses - p0), 32'd0);
        rearm();

        // Random images with gaps; start pulses mid-load must be ignored.
        run_image(3, 50, 1'b1);
        for (int r = 0; r < 3; r++) begin
            rearm();
            run_image(int'($urandom_range(5, 1)), int'($urandom_range(60, 0)), 1'b1);
        end

        // Reset in the middle of the second word.
        rearm();
        w0 = $urandom;
        w1 = $urandom;
        send_word(32'd3, 0);
        send_word(w0, 0);
        send_byte(w1[7:0], 0);
        send_byte(w1[15:8], 0);
        reset = 1'b1;
        #1;
        chk("mid_stall", 32'(bus.cpu_stall), 32'd1);
        chk("mid_words", 32'(bus.words_loaded), 32'd0);
        chk("mid_done", 32'(bus.load_done), 32'd0);
        chk("mid_ready", 32'(bus.byte_ready), 32'd1);
        chk("mid_wr_en", 32'(bus.imem_wr_en), 32'd0);
        chk("mid_ram0", ram[0], w0);
        step();
        reset = 1'b0;
        run_image(1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
